// File: rtl/yarvi_prefetch_pkg.sv
// Shared definitions for the yarvi fetch stage: address-width macros, reset PC and queue entry type.
// The optional YARVI_PREFETCH_SMC_EN build snoops code writes against fetched entries.
`ifndef VMSB
`define VMSB 31
`endif
`ifndef XMSB
`define XMSB 31
`endif
`ifndef RESET_PC
`define RESET_PC 32'h8000_0000
`endif

package yarvi_prefetch_pkg;

  typedef struct packed {
    logic [`VMSB:0] pc;
    logic [31:0]    insn;
  } fe_entry_t;

endpackage

// File: rtl/yarvi_code_ram.sv
// Code RAM: byte-masked write, registered read that returns old data on a same-word collision.
module yarvi_code_ram #(
  parameter int MEM_LOG2 = 12
) (
  input  logic                clock,
  input  logic                rd_en,
  input  logic [MEM_LOG2-1:0] raddr,
  output logic [31:0]         rdata,
  input  logic [MEM_LOG2-1:0] waddr,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wmask
);

  logic [31:0] mem_q [2**MEM_LOG2];
  logic [31:0] rdata_q;

  // Read and write share the edge, so a colliding read sees the pre-write word.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rdata_q <= mem_q[raddr];
    end
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) begin
        mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/yarvi_prefetch.sv
// Fetch stage: sequential PC generation, one outstanding RAM read and a small {pc, insn} queue.
// Define YARVI_PREFETCH_SMC_EN to flush and refetch when a code write hits a fetched word.
module yarvi_prefetch
  import yarvi_prefetch_pkg::*;
#(
  parameter int             QUEUE_LOG2 = 2,
  parameter int             MEM_LOG2   = 12,
  parameter logic [`VMSB:0] RESET_PC   = `RESET_PC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic [`VMSB:0]   restart_pc,
  input  logic [`VMSB:2]   address,
  input  logic [31:0]      writedata,
  input  logic [3:0]       writemask,
  input  logic             ex_ready,
  output logic             fe_valid,
  output logic [`VMSB:0]   fe_pc,
  output logic [31:0]      fe_insn
);

  localparam int DEPTH = 2**QUEUE_LOG2;
  localparam logic [QUEUE_LOG2:0]   CNT_ZERO  = '0;
  localparam logic [QUEUE_LOG2:0]   CNT_ONE   = (QUEUE_LOG2+1)'(1);
  localparam logic [QUEUE_LOG2:0]   CNT_DEPTH = (QUEUE_LOG2+1)'(DEPTH);
  localparam logic [QUEUE_LOG2-1:0] PTR_ZERO  = '0;
  localparam logic [QUEUE_LOG2-1:0] PTR_ONE   = QUEUE_LOG2'(1);
  localparam logic [`VMSB:0]        PC_STEP   = (`VMSB+1)'(4);

  fe_entry_t             queue_q [DEPTH];
  logic [QUEUE_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [QUEUE_LOG2:0]   count_q, count_d, occupancy;
  logic                  inflight_q, inflight_d;
  logic [`VMSB:0]        inflight_pc_q, inflight_pc_d, fetch_pc_q, fetch_pc_d, flush_pc;
  logic                  credit_ok, issue, push, pop, snoop_hit;
  logic [31:0]           rdata;
  logic                  unused_bits;

  assign unused_bits = ^{restart_pc[1:0], address};

  // The in-flight read holds a queue slot, so the queue can never overflow.
  assign occupancy = count_q + (QUEUE_LOG2+1)'(inflight_q);
  assign credit_ok = occupancy < CNT_DEPTH;
  assign fe_valid  = (count_q != CNT_ZERO);
  assign pop       = fe_valid & ex_ready;
  assign fe_pc     = queue_q[rd_ptr_q].pc;
  assign fe_insn   = queue_q[rd_ptr_q].insn;

`ifdef YARVI_PREFETCH_SMC_EN
  // Snoop code writes against queued, in-flight and about-to-issue words; refetch from the oldest unconsumed PC.
  always_comb begin
    logic queue_hit;
    queue_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      queue_hit = queue_hit | (((QUEUE_LOG2+1)'(i) < count_q) &&
                  (queue_q[rd_ptr_q + QUEUE_LOG2'(i)].pc[`VMSB:2] == address));
    end
    snoop_hit = (writemask != 4'b0000) &&
                (queue_hit ||
                 (inflight_q && (inflight_pc_q[`VMSB:2] == address)) ||
                 (credit_ok && (fetch_pc_q[`VMSB:2] == address)));
    if (pop && (count_q > CNT_ONE)) begin
      flush_pc = queue_q[rd_ptr_q + PTR_ONE].pc;
    end else if (!pop && (count_q != CNT_ZERO)) begin
      flush_pc = queue_q[rd_ptr_q].pc;
    end else if (inflight_q) begin
      flush_pc = inflight_pc_q;
    end else begin
      flush_pc = fetch_pc_q;
    end
  end
`else
  assign snoop_hit = 1'b0;
  assign flush_pc  = fetch_pc_q;
`endif

  // Next-state: restart beats snoop flush, which beats normal issue/push/pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    issue         = 1'b0;
    push          = 1'b0;
    if (restart) begin
      fetch_pc_d = {restart_pc[`VMSB:2], 2'b00};
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
      count_d    = CNT_ZERO;
    end else if (snoop_hit) begin
      fetch_pc_d = flush_pc;
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
      count_d    = CNT_ZERO;
    end else begin
      issue = credit_ok;
      push  = inflight_q;
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + PC_STEP;
      end else begin
        inflight_d = 1'b0;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      rd_ptr_q      <= PTR_ZERO;
      wr_ptr_q      <= PTR_ZERO;
      count_q       <= CNT_ZERO;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides validity.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      queue_q[wr_ptr_q] <= '{pc: inflight_pc_q, insn: rdata};
    end
  end

  yarvi_code_ram #(.MEM_LOG2(MEM_LOG2)) u_code_ram (
    .clock (clock),
    .rd_en (issue),
    .raddr (fetch_pc_q[MEM_LOG2+1:2]),
    .rdata (rdata),
    .waddr (address[MEM_LOG2+1:2]),
    .wdata (writedata),
    .wmask (writemask)
  );

endmodule

// File: tb/tb_yarvi_prefetch.sv
// Directed bench for yarvi_prefetch; also covers the snoop path when YARVI_PREFETCH_SMC_EN is defined.
module tb_yarvi_prefetch;

  logic        clock, reset, restart, ex_ready;
  logic [31:0] restart_pc, writedata;
  logic [31:2] address;
  logic [3:0]  writemask;
  logic        fe_valid;
  logic [31:0] fe_pc, fe_insn;
  int          vectors = 0;
  int          errors  = 0;

  yarvi_prefetch dut (
    .clock      (clock),
    .reset      (reset),
    .restart    (restart),
    .restart_pc (restart_pc),
    .address    (address),
    .writedata  (writedata),
    .writemask  (writemask),
    .ex_ready   (ex_ready),
    .fe_valid   (fe_valid),
    .fe_pc      (fe_pc),
    .fe_insn    (fe_insn)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] insn);
    chk({tag, "_valid"}, 32'(fe_valid), 32'd1);
    chk({tag, "_pc"}, fe_pc, pc);
    chk({tag, "_insn"}, fe_insn, insn);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; restart_pc = 32'h0; ex_ready = 1'b1;
    address = 30'd0; writedata = 32'h0; writemask = 4'b0000;
    // Preload words 0..127 with their own index while held in reset.
    for (int w = 0; w < 128; w++) begin
      address = 30'(w); writedata = 32'(w); writemask = 4'b1111;
      step();
    end
    writemask = 4'b0000;
    step();
    reset = 1'b0;

    // Reset state, 2-cycle fill latency, one insn per cycle.
    chk("rst_valid_c0", 32'(fe_valid), 32'd0);
    step();
    chk("rst_valid_c1", 32'(fe_valid), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk_head("stream", 32'h8000_0000 + 32'(4*k), 32'(k));
      step();
    end

    // Reset mid-stream with restart asserted: reset wins, fetch resumes at RESET_PC.
    reset = 1'b1; restart = 1'b1; restart_pc = 32'h8000_0200; ex_ready = 1'b0;
    step();
    reset = 1'b0; restart = 1'b0;
    chk("rst2_valid_c0", 32'(fe_valid), 32'd0);
    chk("rst2_fetch_pc", dut.fetch_pc_q, 32'h8000_0000);
    step();
    chk("rst2_valid_c1", 32'(fe_valid), 32'd0);
    step();
    chk_head("rst2_first", 32'h8000_0000, 32'd0);

    // Stall: exactly four entries queued, fetch parks at 0x80000010.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_hold_pc", fe_pc, 32'h8000_0000);
    end
    chk("stall_count", 32'(dut.count_q), 32'd4);
    chk("stall_fetch_pc", dut.fetch_pc_q, 32'h8000_0010);
    ex_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head("release", 32'h8000_0000 + 32'(4*k), 32'(k));
      step();
    end

    // Refill, then restart while full: old entries are discarded, pop ignored.
    ex_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_head("full_head", 32'h8000_0020, 32'd8);
    chk("full_count", 32'(dut.count_q), 32'd4);
    restart = 1'b1; restart_pc = 32'h8000_0102; ex_ready = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_valid_c1", 32'(fe_valid), 32'd0);
    step();
    chk("rs_valid_c2", 32'(fe_valid), 32'd0);
    step();
    chk_head("rs_first", 32'h8000_0100, 32'd64);
    step();
    chk_head("rs_second", 32'h8000_0104, 32'd65);
    step();
    chk_head("rs_third", 32'h8000_0108, 32'd66);

    // Write word 5 in the cycle it is read.
    restart = 1'b1; restart_pc = 32'h8000_0014;
    step();
    restart = 1'b0;
    address = 30'd5; writedata = 32'hDEAD_BEEF; writemask = 4'b0011;
    chk("wr_valid_c1", 32'(fe_valid), 32'd0);
    step();
    writemask = 4'b0000;
    chk("wr_valid_c2", 32'(fe_valid), 32'd0);
    step();
`ifdef YARVI_PREFETCH_SMC_EN
    chk("wr_valid_c3", 32'(fe_valid), 32'd0);
    step();
    chk_head("wr_collide", 32'h8000_0014, 32'h0000_BEEF);
`else
    chk_head("wr_collide", 32'h8000_0014, 32'h0000_0005);
`endif
    step();
    chk_head("wr_next", 32'h8000_0018, 32'd6);
    restart = 1'b1; restart_pc = 32'h8000_0014;
    step();
    restart = 1'b0;
    step();
    step();
    chk_head("wr_refetch", 32'h8000_0014, 32'h0000_BEEF);

`ifdef YARVI_PREFETCH_SMC_EN
    // Snoop hit on a queued word flushes and refetches from the head.
    restart = 1'b1; restart_pc = 32'h8000_0008; ex_ready = 1'b0;
    step();
    restart = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk_head("smc_full", 32'h8000_0008, 32'd2);
    address = 30'd4; writedata = 32'h1234_5678; writemask = 4'b1111;
    step();
    writemask = 4'b0000;
    chk("smc_valid_c1", 32'(fe_valid), 32'd0);
    step();
    chk("smc_valid_c2", 32'(fe_valid), 32'd0);
    step();
    ex_ready = 1'b1;
    chk_head("smc_re0", 32'h8000_0008, 32'd2);
    step();
    chk_head("smc_re1", 32'h8000_000C, 32'd3);
    step();
    chk_head("smc_re2", 32'h8000_0010, 32'h1234_5678);
    step();
    chk_head("smc_re3", 32'h8000_0014, 32'h0000_BEEF);
    step();
    chk_head("smc_re4", 32'h8000_0018, 32'd6);
    // Snoop hit and restart together: restart target wins.
    ex_ready = 1'b0;
    address = 30'd6; writedata = 32'hAAAA_AAAA; writemask = 4'b1111;
    restart = 1'b1; restart_pc = 32'h8000_0180;
    step();
    writemask = 4'b0000; restart = 1'b0;
    chk("smcrs_valid_c1", 32'(fe_valid), 32'd0);
    step();
    chk("smcrs_valid_c2", 32'(fe_valid), 32'd0);
    step();
    chk_head("smcrs_first", 32'h8000_0180, 32'd96);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
